// File: rtl/sokoban_stage_sequencer.sv
// -----------------------------------------------------------------------------
// sokoban_stage_sequencer
//
// Purpose: top-level game-flow controller. Owns the current stage index and
// walks the game through map load, play, a win hold-off, stage advance and
// the all-clear screen. Gates player input to the move engine and keeps a
// per-attempt move count for display.
//
// Optional feature macro: STAGE_SELECT_EN
//   Defined   -> adds i_sel_valid / i_sel_stage for direct stage selection
//                from IDLE, PLAY or DONE.
//   Undefined -> those ports are absent; stages advance only sequentially.
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous, active-high reset
//   i_sel_valid   in   (STAGE_SELECT_EN only) pulse; jump to i_sel_stage
//   i_sel_stage   in   (STAGE_SELECT_EN only) requested stage index
//   i_start       in   pulse; begin game from stage 0 (IDLE or DONE only)
//   i_restart     in   pulse; reload current stage (PLAY only)
//   i_win         in   level; all boxes on targets
//   i_move_valid  in   pulse; one accepted player move
//   i_tick        in   one-cycle frame/timebase strobe
//   i_load_done   in   map loader acknowledge
//   o_load_req    out  request map load of o_stage
//   o_play_en     out  player input enabled
//   o_stage       out  current stage index
//   o_moves       out  moves in current attempt (saturating)
//   o_stage_adv   out  one-cycle pulse on stage increment
//   o_all_clear   out  final stage cleared
//   o_state       out  debug view of the FSM state encoding
//
// Loader handshake: o_load_req rises on entry to LOAD and stays high until
// i_load_done is sampled high on a clock edge; that same edge drops
// o_load_req and enters PLAY. i_load_done outside LOAD is ignored.
// All outputs are registered.
// -----------------------------------------------------------------------------
module sokoban_stage_sequencer #(
  parameter int N_STAGES       = 2,
  parameter int STAGE_BITS     = 2,
  parameter int WIN_HOLD_TICKS = 60,
  parameter int HOLD_BITS      = 6,
  parameter int MOVE_BITS      = 10
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef STAGE_SELECT_EN
  input  logic                  i_sel_valid,
  input  logic [STAGE_BITS-1:0] i_sel_stage,
`endif
  input  logic                  i_start,
  input  logic                  i_restart,
  input  logic                  i_win,
  input  logic                  i_move_valid,
  input  logic                  i_tick,
  input  logic                  i_load_done,
  output logic                  o_load_req,
  output logic                  o_play_en,
  output logic [STAGE_BITS-1:0] o_stage,
  output logic [MOVE_BITS-1:0]  o_moves,
  output logic                  o_stage_adv,
  output logic                  o_all_clear,
  output logic [2:0]            o_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_PLAY     = 3'd2,
    S_WIN_HOLD = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [STAGE_BITS-1:0] LAST_STAGE = STAGE_BITS'(N_STAGES - 1);
  localparam logic [HOLD_BITS-1:0]  HOLD_END   = HOLD_BITS'(WIN_HOLD_TICKS);

  state_t                r_state;
  logic [STAGE_BITS-1:0] r_stage;
  logic [MOVE_BITS-1:0]  r_moves;
  logic [HOLD_BITS-1:0]  r_hold;
  logic                  r_load_req;
  logic                  r_play_en;
  logic                  r_stage_adv;
  logic                  r_all_clear;

  logic                  w_sel_hit;
  logic [STAGE_BITS-1:0] w_sel_stage;
  logic [MOVE_BITS-1:0]  w_moves_inc;
  logic [HOLD_BITS-1:0]  w_hold_inc;
  logic                  w_hold_done;

  // An out-of-range selection is dropped entirely, so it never reaches the FSM.
`ifdef STAGE_SELECT_EN
  assign w_sel_hit   = i_sel_valid && (32'(i_sel_stage) < N_STAGES);
  assign w_sel_stage = i_sel_stage;
`else
  assign w_sel_hit   = 1'b0;
  assign w_sel_stage = '0;
`endif

  // Move counter sticks at all-ones instead of wrapping.
  assign w_moves_inc = (r_moves == '1) ? r_moves : r_moves + 1'b1;
  assign w_hold_inc  = r_hold + 1'b1;
  assign w_hold_done = (w_hold_inc == HOLD_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_stage     <= '0;
      r_moves     <= '0;
      r_hold      <= '0;
      r_load_req  <= 1'b0;
      r_play_en   <= 1'b0;
      r_stage_adv <= 1'b0;
      r_all_clear <= 1'b0;
    end else begin
      r_stage_adv <= 1'b0;
      case (r_state)
        // IDLE and DONE share entry rules; start wins over a same-cycle
        // selection so the "new game" button is never overridden.
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state     <= S_LOAD;
            r_stage     <= '0;
            r_moves     <= '0;
            r_load_req  <= 1'b1;
            r_all_clear <= 1'b0;
          end else if (w_sel_hit) begin
            r_state     <= S_LOAD;
            r_stage     <= w_sel_stage;
            r_moves     <= '0;
            r_load_req  <= 1'b1;
            r_all_clear <= 1'b0;
          end
        end

        S_LOAD: begin
          if (i_load_done) begin
            r_load_req <= 1'b0;
            r_play_en  <= 1'b1;
            r_state    <= S_PLAY;
          end
        end

        // Priority: win > select > restart > move. A move arriving with win
        // still counts toward the finished attempt.
        S_PLAY: begin
          if (i_win) begin
            r_state   <= S_WIN_HOLD;
            r_play_en <= 1'b0;
            r_hold    <= '0;
            if (i_move_valid) begin
              r_moves <= w_moves_inc;
            end
          end else if (w_sel_hit) begin
            r_state    <= S_LOAD;
            r_stage    <= w_sel_stage;
            r_moves    <= '0;
            r_play_en  <= 1'b0;
            r_load_req <= 1'b1;
          end else if (i_restart) begin
            r_state    <= S_LOAD;
            r_moves    <= '0;
            r_play_en  <= 1'b0;
            r_load_req <= 1'b1;
          end else if (i_move_valid) begin
            r_moves <= w_moves_inc;
          end
        end

        // Committed once entered: only ticks matter here.
        S_WIN_HOLD: begin
          if (i_tick) begin
            r_hold <= w_hold_inc;
            if (w_hold_done) begin
              if (r_stage == LAST_STAGE) begin
                r_state     <= S_DONE;
                r_all_clear <= 1'b1;
              end else begin
                r_state     <= S_LOAD;
                r_stage     <= r_stage + 1'b1;
                r_stage_adv <= 1'b1;
                r_moves     <= '0;
                r_load_req  <= 1'b1;
              end
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_load_req  = r_load_req;
  assign o_play_en   = r_play_en;
  assign o_stage     = r_stage;
  assign o_moves     = r_moves;
  assign o_stage_adv = r_stage_adv;
  assign o_all_clear = r_all_clear;
  assign o_state     = r_state;

endmodule

// File: tb/tb_sokoban_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sokoban_stage_sequencer
//
// Directed bench for sokoban_stage_sequencer with WIN_HOLD_TICKS=3 and
// MOVE_BITS=3. The driver applies inputs just after a rising edge, lets one
// edge pass, and pushes the hand-computed output snapshot for that cycle into
// exp_q. The monitor runs on falling edges and pops/compares every snapshot
// tagged with the current cycle. Snapshot layout:
//   {state[2:0], load_req, play_en, stage[1:0], moves[2:0], stage_adv, all_clear}
// -----------------------------------------------------------------------------
module tb_sokoban_stage_sequencer;

  localparam int W = 12;
  localparam int ST_IDLE = 0;
  localparam int ST_LOAD = 1;
  localparam int ST_PLAY = 2;
  localparam int ST_WH   = 3;
  localparam int ST_DONE = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, restart, win, move_valid, tick, load_done;
  logic       sel_valid;
  logic [1:0] sel_stage;
  logic       load_req, play_en, stage_adv, all_clear;
  logic [1:0] stage;
  logic [2:0] moves;
  logic [2:0] state;

  logic [W-1:0] exp_q[$];
  int           cyc_q[$];
  string        name_q[$];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sokoban_stage_sequencer #(
    .N_STAGES(2), .STAGE_BITS(2), .WIN_HOLD_TICKS(3), .HOLD_BITS(2), .MOVE_BITS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef STAGE_SELECT_EN
    .i_sel_valid(sel_valid),
    .i_sel_stage(sel_stage),
`endif
    .i_start(start),
    .i_restart(restart),
    .i_win(win),
    .i_move_valid(move_valid),
    .i_tick(tick),
    .i_load_done(load_done),
    .o_load_req(load_req),
    .o_play_en(play_en),
    .o_stage(stage),
    .o_moves(moves),
    .o_stage_adv(stage_adv),
    .o_all_clear(all_clear),
    .o_state(state)
  );

  // ---------------- driver tasks ----------------
  function automatic logic [W-1:0] pk(input int st, input int lr, input int pe,
                                      input int stg, input int mv,
                                      input int adv, input int ac);
    return {st[2:0], lr[0], pe[0], stg[1:0], mv[2:0], adv[0], ac[0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string nm, input logic [W-1:0] v);
    exp_q.push_back(v);
    cyc_q.push_back(cyc);
    name_q.push_back(nm);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    int           c;
    string        nm;
    act = {state, load_req, play_en, stage, moves, stage_adv, all_clear};
    while (exp_q.size() > 0 && cyc_q[0] <= cyc) begin
      e  = exp_q.pop_front();
      c  = cyc_q.pop_front();
      nm = name_q.pop_front();
      n_checks++;
      if (c != cyc) begin
        n_errors++;
        $display("FAIL %s: sampled at cycle %0d, required cycle %0d", nm, cyc, c);
      end else if (act !== e) begin
        n_errors++;
        $display("FAIL %s: actual=%b required=%b (state,load_req,play_en,stage,moves,stage_adv,all_clear)",
                 nm, act, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 0; restart = 0; win = 0; move_valid = 0; tick = 0;
    load_done = 0; sel_valid = 0; sel_stage = '0;
    step(); step();
    expect_now("reset", pk(ST_IDLE, 0, 0, 0, 0, 0, 0));

    rst = 1'b0; start = 1; step();
    expect_now("start_load", pk(ST_LOAD, 1, 0, 0, 0, 0, 0));
    start = 0; step();
    expect_now("load_wait1", pk(ST_LOAD, 1, 0, 0, 0, 0, 0));
    step();
    expect_now("load_wait2", pk(ST_LOAD, 1, 0, 0, 0, 0, 0));
    load_done = 1; step();
    expect_now("load_done_play", pk(ST_PLAY, 0, 1, 0, 0, 0, 0));
    load_done = 0; tick = 1; step();
    expect_now("tick_in_play", pk(ST_PLAY, 0, 1, 0, 0, 0, 0));
    tick = 0;

    for (int i = 1; i <= 4; i++) begin
      move_valid = 1; step();
      expect_now("move_count", pk(ST_PLAY, 0, 1, 0, i, 0, 0));
    end
    win = 1; step();
    expect_now("win_with_move", pk(ST_WH, 0, 0, 0, 5, 0, 0));
    win = 0; restart = 1; step();
    expect_now("wh_ignores_inputs", pk(ST_WH, 0, 0, 0, 5, 0, 0));
    move_valid = 0; restart = 0;

    tick = 1; step();
    expect_now("hold_tick1", pk(ST_WH, 0, 0, 0, 5, 0, 0));
    tick = 0; step();
    expect_now("hold_gap", pk(ST_WH, 0, 0, 0, 5, 0, 0));
    tick = 1; step();
    expect_now("hold_tick2", pk(ST_WH, 0, 0, 0, 5, 0, 0));
    step();
    expect_now("stage_adv", pk(ST_LOAD, 1, 0, 1, 0, 1, 0));
    tick = 0; start = 1; step();
    expect_now("adv_pulse_end", pk(ST_LOAD, 1, 0, 1, 0, 0, 0));
    start = 0;

    load_done = 1; step();
    expect_now("stage1_play", pk(ST_PLAY, 0, 1, 1, 0, 0, 0));
    load_done = 0; move_valid = 1; step();
    expect_now("stage1_move", pk(ST_PLAY, 0, 1, 1, 1, 0, 0));
    restart = 1; step();
    expect_now("restart_with_move", pk(ST_LOAD, 1, 0, 1, 0, 0, 0));
    restart = 0; move_valid = 0;
    load_done = 1; step();
    expect_now("reload_play", pk(ST_PLAY, 0, 1, 1, 0, 0, 0));
    load_done = 0;

    win = 1; restart = 1; step();
    expect_now("win_over_restart", pk(ST_WH, 0, 0, 1, 0, 0, 0));
    win = 0; restart = 0; tick = 1;
    step();
    expect_now("last_hold1", pk(ST_WH, 0, 0, 1, 0, 0, 0));
    step();
    expect_now("last_hold2", pk(ST_WH, 0, 0, 1, 0, 0, 0));
    step();
    expect_now("all_clear", pk(ST_DONE, 0, 0, 1, 0, 0, 1));
    tick = 0; load_done = 1; step();
    expect_now("done_ignores_load_done", pk(ST_DONE, 0, 0, 1, 0, 0, 1));
    load_done = 0; start = 1; step();
    expect_now("start_from_done", pk(ST_LOAD, 1, 0, 0, 0, 0, 0));
    start = 0; load_done = 1; step();
    expect_now("stage0_play", pk(ST_PLAY, 0, 1, 0, 0, 0, 0));
    load_done = 0;

    for (int i = 1; i <= 9; i++) begin
      move_valid = 1;
      start = (i == 2);
      step();
      expect_now("move_saturate", pk(ST_PLAY, 0, 1, 0, (i > 7) ? 7 : i, 0, 0));
    end
    move_valid = 0; start = 0;

    restart = 1; step();
    expect_now("restart_clears", pk(ST_LOAD, 1, 0, 0, 0, 0, 0));
    restart = 0; rst = 1; step();
    expect_now("rst_mid_load", pk(ST_IDLE, 0, 0, 0, 0, 0, 0));
    rst = 0; load_done = 1; step();
    expect_now("stray_load_done", pk(ST_IDLE, 0, 0, 0, 0, 0, 0));
    load_done = 0;

`ifdef STAGE_SELECT_EN
    sel_valid = 1; sel_stage = 2'd3; step();
    expect_now("sel_out_of_range", pk(ST_IDLE, 0, 0, 0, 0, 0, 0));
    sel_stage = 2'd1; step();
    expect_now("sel_from_idle", pk(ST_LOAD, 1, 0, 1, 0, 0, 0));
    sel_valid = 0; load_done = 1; step();
    expect_now("sel_play", pk(ST_PLAY, 0, 1, 1, 0, 0, 0));
    load_done = 0;
`endif

    step(); step();
    // Anything left unconsumed was never checked against the DUT.
    while (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: never sampled, required=%b", name_q.pop_front(), exp_q.pop_front());
      void'(cyc_q.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sokoban_stage_sequencer.md
Name: sokoban_stage_sequencer

Overview:
- Top-level game-flow controller; owns the current stage index.
- Sequences: map load, play, win hold-off, stage advance, all-clear.
- Handshakes with the map loader (load_req/load_done).
- Gates player input to the move engine (play_en) and keeps a per-stage move count for display.

Parameters:
- N_STAGES, 2: number of stages; valid indices 0..N_STAGES-1.
- STAGE_BITS, 2: width of stage; must satisfy 2^STAGE_BITS >= N_STAGES.
- WIN_HOLD_TICKS, 60: tick pulses to wait in WIN_HOLD before advancing; must be >= 1.
- HOLD_BITS, 6: width of the hold counter; must hold WIN_HOLD_TICKS.
- MOVE_BITS, 10: width of the move counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begin game from stage 0 (IDLE or DONE only)
- restart  in  1  pulse; reload current stage (PLAY only)
- win  in  1  level; all boxes on targets (from map checker)
- move_valid  in  1  pulse; one accepted player move
- tick  in  1  one-cycle frame/timebase strobe
- load_done  in  1  map loader acknowledge
- load_req  out  1  request map load of stage
- play_en  out  1  player input enabled
- stage  out  STAGE_BITS  current stage index
- moves  out  MOVE_BITS  moves in current attempt
- stage_adv  out  1  one-cycle pulse on stage increment
- all_clear  out  1  final stage cleared

Behaviour:
- Reset: synchronous, active-high; reset is rst, clock is clk.
  - Reset values: state=IDLE, stage=0, moves=0, hold=0, all outputs 0.
  - rst in any state, including mid-LOAD, aborts immediately; load_req drops the next edge.
- All outputs are registered (no combinational path from inputs).
- States: IDLE, LOAD, PLAY, WIN_HOLD, DONE.
- IDLE:
  - Outputs quiescent.
  - start -> LOAD; stage=0, moves=0.
- LOAD:
  - load_req=1, held until load_done is sampled high.
  - On that edge: load_req=0 and state -> PLAY (load_req drops the cycle after load_done is seen).
  - play_en=0 throughout.
  - A load_done seen in any other state is ignored.
- PLAY:
  - play_en=1.
  - move_valid: moves+1, saturating at all-ones.
  - Event priority: win > restart > move_valid.
    - win: -> WIN_HOLD; hold=0, play_en=0 next cycle; the same-cycle move_valid is still counted.
    - restart (no win): -> LOAD; moves=0, stage unchanged.
- WIN_HOLD:
  - play_en=0; moves frozen.
  - Each tick increments hold.
  - When a tick brings hold to WIN_HOLD_TICKS:
    - If stage==N_STAGES-1: -> DONE.
    - Else: stage+1, stage_adv=1 for exactly one cycle, moves=0, -> LOAD.
  - win, restart and move_valid are ignored here (win dropping does not abort).
- DONE:
  - all_clear=1; stage and moves hold their final values.
  - start -> LOAD; stage=0, moves=0, all_clear=0.
- Other rules:
  - start outside IDLE/DONE is ignored.
  - stage never exceeds N_STAGES-1; no wrap occurs except via start in DONE.
  - tick outside WIN_HOLD is ignored.

Optional Feature:
- Macro: STAGE_SELECT_EN.
- Defined:
  - Adds ports sel_valid (in, 1) and sel_stage (in, STAGE_BITS).
  - sel_valid in IDLE, PLAY or DONE: stage=sel_stage, moves=0, all_clear=0, -> LOAD.
  - Priority in PLAY: win > sel_valid > restart.
  - sel_stage >= N_STAGES is ignored entirely (no state change).
  - sel_valid in LOAD or WIN_HOLD is ignored.
- Undefined: ports absent; stages are reachable only sequentially.

Test Plan:
- Reset then start; load_done 3 cycles later -> load_req high for exactly those cycles; play_en=1 the cycle after; stage=0, moves=0.
- In PLAY, 5 move_valid pulses with win asserted on the 5th -> moves=5 frozen; WIN_HOLD_TICKS=3 ticks -> one stage_adv pulse, stage=1, moves=0, load_req=1.
- Stage 1 (last, N_STAGES=2): win then 3 ticks -> DONE, all_clear=1, stage=1, no stage_adv; then start -> stage=0, LOAD, all_clear=0.
- PLAY with restart and move_valid in the same cycle -> LOAD, moves=0, stage unchanged; win and restart together -> WIN_HOLD.
- MOVE_BITS=3: 9 moves -> moves=7 (saturated); rst asserted mid-LOAD -> IDLE, load_req=0 next cycle, and a subsequent stray load_done is ignored.
- STAGE_SELECT_EN: sel_valid with sel_stage=1 in IDLE -> LOAD with stage=1; sel_stage=3 with N_STAGES=2 -> no change.
